// File: rtl/alu_sequencer_pkg.sv
// Shared opcodes, ALU function selects and sequencer state encoding.
// The ALU select codes are also used by the ALU itself.
package alu_sequencer_pkg;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_NOR = 4'b0011;
   localparam logic [3:0] OP_LDA = 4'b0100;
   localparam logic [3:0] OP_STA = 4'b0101;
   localparam logic [3:0] OP_LDI = 4'b0110;
   localparam logic [3:0] OP_JMP = 4'b0111;
   localparam logic [3:0] OP_JZ  = 4'b1000;
   localparam logic [3:0] OP_SHL = 4'b1011;
   localparam logic [3:0] OP_SHR = 4'b1100;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_NOR  = 4'b0011;
   localparam logic [3:0] ALU_SHL  = 4'b1011;
   localparam logic [3:0] ALU_SHR  = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_EXECUTE = 3'd3,
      ST_WBACK   = 3'd4,
      ST_OPERAND = 3'd5,
      ST_JUMP    = 3'd6,
      ST_HALT    = 3'd7
   } state_e;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational opcode classifier; unknown opcodes fall through as NOP.
module instr_decode
   import alu_sequencer_pkg::*;
(
   input  logic [3:0] opcode_i,
   output logic       isAlu_o,
   output logic [3:0] aluSel_o,
   output logic       isLoad_o,
   output logic       isLoadImm_o,
   output logic       isStore_o,
   output logic       isJump_o,
   output logic       isJz_o,
   output logic       isHalt_o
);

   // Opcode to control-class lookup
   always_comb begin
      isAlu_o     = 1'b0;
      aluSel_o    = ALU_NONE;
      isLoad_o    = 1'b0;
      isLoadImm_o = 1'b0;
      isStore_o   = 1'b0;
      isJump_o    = 1'b0;
      isJz_o      = 1'b0;
      isHalt_o    = 1'b0;
      case (opcode_i)
         OP_ADD: begin isAlu_o = 1'b1; aluSel_o = ALU_ADD; end
         OP_SUB: begin isAlu_o = 1'b1; aluSel_o = ALU_SUB; end
         OP_NOR: begin isAlu_o = 1'b1; aluSel_o = ALU_NOR; end
         OP_SHL: begin isAlu_o = 1'b1; aluSel_o = ALU_SHL; end
         OP_SHR: begin isAlu_o = 1'b1; aluSel_o = ALU_SHR; end
         OP_LDA: isLoad_o    = 1'b1;
         OP_STA: isStore_o   = 1'b1;
         OP_LDI: isLoadImm_o = 1'b1;
         OP_JMP: isJump_o    = 1'b1;
         OP_JZ:  isJz_o      = 1'b1;
         OP_HLT: isHalt_o    = 1'b1;
         default: isAlu_o    = 1'b0;
      endcase
   end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit datapath.
// Owns PC, IR, ACC and the {Z,C,N} flag register.
module alu_sequencer
   import alu_sequencer_pkg::*;
#(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter int         RF_AW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             run_i,
   output logic [7:0]       imemAddr_o,
   input  logic [7:0]       imemData_i,
   output logic [RF_AW-1:0] rfAddr_o,
   input  logic [7:0]       rfRdata_i,
   output logic [7:0]       rfWdata_o,
   output logic             rfWe_o,
   output logic [3:0]       aluOp_o,
   output logic [7:0]       aluA_o,
   output logic [7:0]       aluB_o,
   input  logic [7:0]       aluResult_i,
   input  logic             aluZ_i,
   input  logic             aluC_i,
   input  logic             aluN_i,
   output logic [7:0]       acc_o,
   output logic [2:0]       flags_o,
   output logic             halted_o
);

   state_e     state_q, state_d;
   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] acc_q, acc_d;
   logic [2:0] flags_q, flags_d;
   logic [7:0] res_q, res_d;
   logic [2:0] resFlags_q, resFlags_d;
   logic [3:0] aluOp_q, aluOp_d;
   logic       rfWe_q, rfWe_d;
   logic       halted_q, halted_d;

   logic [3:0] decOpcode_s;
   logic       isAlu_s, isLoad_s, isLoadImm_s, isStore_s, isJump_s, isJz_s, isHalt_s;
   logic [3:0] aluSel_s;

   // In DECODE the fresh instruction byte is classified before it lands in IR.
   assign decOpcode_s = (state_q == ST_DECODE) ? imemData_i[7:4] : ir_q[7:4];

   instr_decode u_decode (
      .opcode_i    (decOpcode_s),
      .isAlu_o     (isAlu_s),
      .aluSel_o    (aluSel_s),
      .isLoad_o    (isLoad_s),
      .isLoadImm_o (isLoadImm_s),
      .isStore_o   (isStore_s),
      .isJump_o    (isJump_s),
      .isJz_o      (isJz_s),
      .isHalt_o    (isHalt_s)
   );

   // Sequencer state and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         ir_q       <= 8'h00;
         acc_q      <= 8'h00;
         flags_q    <= 3'b000;
         res_q      <= 8'h00;
         resFlags_q <= 3'b000;
         aluOp_q    <= ALU_NONE;
         rfWe_q     <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         acc_q      <= acc_d;
         flags_q    <= flags_d;
         res_q      <= res_d;
         resFlags_q <= resFlags_d;
         aluOp_q    <= aluOp_d;
         rfWe_q     <= rfWe_d;
         halted_q   <= halted_d;
      end
   end

   // Next state; aluOp/rfWe/halted are computed one cycle ahead so they come straight from flops
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      acc_d      = acc_q;
      flags_d    = flags_q;
      res_d      = res_q;
      resFlags_d = resFlags_q;
      aluOp_d    = ALU_NONE;
      rfWe_d     = 1'b0;
      halted_d   = halted_q;
      case (state_q)
         ST_IDLE: begin
            if (run_i) begin
               pc_d    = RESET_PC;
               state_d = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: state_d = ST_DECODE;
         ST_DECODE: begin
            ir_d = imemData_i;
            pc_d = pc_q + 8'h01;
            if (isJump_s || isJz_s) begin
               state_d = ST_OPERAND;
            end else if (isHalt_s) begin
               state_d  = ST_HALT;
               halted_d = 1'b1;
            end else begin
               state_d = ST_EXECUTE;
               aluOp_d = isAlu_s ? aluSel_s : ALU_NONE;
            end
         end
         ST_EXECUTE: begin
            // ALU output is captured here because aluOp drops back to idle in WBACK.
            res_d      = aluResult_i;
            resFlags_d = {aluZ_i, aluC_i, aluN_i};
            rfWe_d     = isStore_s;
            state_d    = ST_WBACK;
         end
         ST_WBACK: begin
            if (isAlu_s) begin
               acc_d   = res_q;
               flags_d = resFlags_q;
            end else if (isLoad_s) begin
               acc_d = rfRdata_i;
            end else if (isLoadImm_s) begin
               acc_d = {4'h0, ir_q[3:0]};
            end else begin
               acc_d = acc_q;
            end
            state_d = ST_FETCH;
         end
         ST_OPERAND: state_d = ST_JUMP;
         ST_JUMP: begin
            if (isJump_s || (isJz_s && flags_q[2])) begin
               pc_d = imemData_i;
            end else begin
               pc_d = pc_q + 8'h01;
            end
            state_d = ST_FETCH;
         end
         ST_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign imemAddr_o = pc_q;
   assign rfAddr_o   = ir_q[RF_AW-1:0];
   assign rfWdata_o  = acc_q;
   assign rfWe_o     = rfWe_q;
   assign aluOp_o    = aluOp_q;
   assign aluA_o     = rfRdata_i;
   assign aluB_o     = acc_q;
   assign acc_o      = acc_q;
   assign flags_o    = flags_q;
   assign halted_o   = halted_q;

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Multi-cycle control unit for the 8-bit microcontroller datapath. It fetches instructions from a synchronous-read program memory, decodes them, and drives the 8-bit ALU select and the register-file ports. It owns the program counter, the accumulator (ACC) and the Z/C/N flag register. It sits between program memory, the register file and the ALU, and sequences one instruction at a time.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset and when leaving IDLE
RF_AW, 4, register-file address width; equals the instruction operand field width

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
run  input  1  level; starts execution from IDLE
imemAddr  output  8  program memory address (= PC)
imemData  input  8  program memory read data; valid the cycle after imemAddr is presented
rfAddr  output  RF_AW  register-file read/write address (= IR[3:0])
rfRdata  input  8  register-file combinational read data
rfWdata  output  8  register-file write data (= ACC)
rfWe  output  1  register-file write enable, one-cycle pulse
aluOp  output  4  ALU function select
aluA  output  8  ALU operand A (= rfRdata)
aluB  output  8  ALU operand B (= ACC)
aluResult  input  8  ALU result
aluZ, aluC, aluN  input  1 each  ALU flags
acc  output  8  current ACC value
flags  output  3  {Z,C,N} flag register
halted  output  1  high in HALT state

Behaviour:
- Reset (async, any state, mid-instruction included): state=IDLE, PC=RESET_PC, IR=0, ACC=0, flags=0, rfWe=0, aluOp=4'b0000, halted=0.
- Instruction format: IR[7:4] opcode, IR[3:0] register address or immediate.
- Opcodes: 0000 NOP; 0001 ADD; 0010 SUB; 0011 NOR; 0100 LDA (ACC<=R); 0101 STA (R<=ACC); 0110 LDI (ACC<={4'h0,imm}); 0111 JMP addr; 1000 JZ addr; 1011 SHL; 1100 SHR; 1111 HLT. All other opcodes execute as NOP.
- aluOp codes: ADD=0001, SUB=0010, NOR=0011, SHL=1011, SHR=1100. aluOp is nonzero only in EXECUTE for those five opcodes, and 0000 in every other state.
- States:
  - IDLE: waits for run=1, then loads PC=RESET_PC and goes to FETCH.
  - FETCH: presents imemAddr=PC, then goes to DECODE.
  - DECODE: IR<=imemData; PC<=PC+1 (8-bit wrap, FF->00).
    - If the opcode is JMP or JZ, go to OPERAND.
    - If HLT, go to HALT.
    - Otherwise go to EXECUTE.
  - EXECUTE: drives rfAddr, aluOp, aluA and aluB, then goes to WBACK.
  - WBACK: commits the instruction, then goes to FETCH.
    - ALU ops: ACC<=aluResult; flags<={aluZ,aluC,aluN}.
    - LDA: ACC<=rfRdata.
    - LDI: ACC<=imm.
    - STA: rfWe=1 for this cycle only.
    - NOP: no state change.
    - Flags change only on ALU ops.
  - OPERAND: presents imemAddr=PC, then goes to JUMP.
  - JUMP:
    - JMP: PC<=imemData.
    - JZ: if Z=1, PC<=imemData; otherwise PC<=PC+1 to skip the operand byte.
    - Then goes to FETCH.
  - HALT: all outputs idle and halted=1. Exits only via reset; run is ignored.
- Latency: every instruction takes exactly 4 clocks from FETCH to the next FETCH.
- JZ tests the flag register as it stands at JUMP, i.e. the result of the last committed ALU op.
- run is sampled only in IDLE. Deasserting run mid-program has no effect.
- rfAddr always equals IR[3:0], including outside EXECUTE/WBACK. rfWdata always equals ACC.

Decomposition:
- Shared package holds:
  - opcode localparams (OP_NOP…OP_HLT)
  - ALU select codes (ALU_ADD=4'b0001, ALU_SUB=4'b0010, ALU_NOR=4'b0011, ALU_SHL=4'b1011, ALU_SHR=4'b1100)
  - state encoding
- The ALU package constants are shared with the ALU itself.
- One natural sub-module: instr_decode. It is combinational: opcode in; out isAlu, aluSel, isLoad, isLoadImm, isStore, isJump, isJz, isHalt.

Test Plan:
- Reset then run=1; program LDI 5 (0x65), HLT (0xF0) -> acc=0x05 at cycle 4 after FETCH; halted=1; PC=0x02.
- R3=0xFF; program LDI 1, ADD R3 (0x13) -> acc=0x00, flags Z=1 C=1 N=0; aluOp=0001 only during the EXECUTE cycle.
- Program LDI 2, STA R7 (0x57), SUB R7 (0x27) -> one rfWe pulse with rfAddr=7, rfWdata=0x02; then acc=0x00, Z=1.
- JZ taken and not taken: with Z=1, JZ 0x10 -> next FETCH at 0x10. With Z=0 -> next FETCH at the original PC+2.
- PC wrap: NOP at 0xFF -> next fetch at 0x00. JMP whose opcode byte is at 0xFE -> operand read from 0xFF.
- Assert rst during EXECUTE of ADD -> all outputs at reset values immediately (async), ACC/flags unchanged from 0, state=IDLE.
